if_fetch_unit: RTL

//  Instruction-fetch stage that produces the instruction word latched by the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage owning the PC, running the imem req/ack handshake, with stall hold and redirect flush
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ins_code,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ins_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;
  localparam logic [ADDR_W-1:0] PC0 = RESET_PC & ~ADDR_W'(3);
  state_t state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, addr_d, p4_d, pc_inc, rpc;
  logic [31:0] hold_buf, buf_d, code_d;
  logic req_d, valid_d, deliver;
  assign pc_inc = pc + ADDR_W'(4);
  assign rpc = redirect_pc & ~ADDR_W'(3);
  assign deliver = !stall && (state == HOLD || (state == FETCH && imem_ack));
  // next-state and next-output selection; redirect outranks stall and ack
  always_comb begin
    state_d = state;
    pc_d = pc;
    req_d = imem_req;
    addr_d = imem_addr;
    p4_d = pc_plus4;
    buf_d = hold_buf;
    code_d = stall ? ins_code : NOP_WORD;
    valid_d = stall & ins_valid;
    if (state == IDLE) begin
      state_d = FETCH;
      req_d = 1'b1;
      addr_d = pc;
    end else if (redirect) begin
      pc_d = rpc;
      code_d = NOP_WORD;
      valid_d = 1'b0;
      buf_d = NOP_WORD;
      state_d = (state == HOLD || imem_ack) ? FETCH : DROP;
      req_d = 1'b1;
      addr_d = (state == HOLD || imem_ack) ? rpc : imem_addr;
    end else if (deliver) begin
      code_d = (state == HOLD) ? hold_buf : imem_rdata;
      valid_d = 1'b1;
      p4_d = pc_inc;
      pc_d = pc_inc;
      addr_d = pc_inc;
      req_d = 1'b1;
      state_d = FETCH;
    end else if (state == FETCH && imem_ack) begin
      buf_d = imem_rdata;
      req_d = 1'b0;
      state_d = HOLD;
    end else if (state == DROP && imem_ack) begin
      addr_d = pc;
      state_d = FETCH;
    end
  end
  // registered state and outputs, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= PC0;
      imem_req <= 1'b0;
      imem_addr <= PC0;
      ins_code <= NOP_WORD;
      pc_plus4 <= '0;
      ins_valid <= 1'b0;
      hold_buf <= NOP_WORD;
    end else begin
      state <= state_d;
      pc <= pc_d;
      imem_req <= req_d;
      imem_addr <= addr_d;
      ins_code <= code_d;
      pc_plus4 <= p4_d;
      ins_valid <= valid_d;
      hold_buf <= buf_d;
    end
  end
endmodule
